board_mem_arbiter: RTL
======================

BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

Interface
REQ-001 SHALL have parameter BOARD_DIM, default 11: board squares per side.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: consecutive denied game cycles before the game requester is forced through.
REQ-003 SHALL have port clk  in  1: single clock (25 MHz pixel clock domain). All logic SHALL be on the rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-005 SHALL have ports disp_req in 1, disp_x in 4, disp_y in 4: display cell read request.
REQ-006 SHALL have ports disp_valid out 1, disp_data out 2, disp_stall out 1: display read response.
REQ-007 SHALL have ports game_req in 1, game_we in 1, game_x in 4, game_y in 4, game_wdata in 2: game-logic request, held until ack.
REQ-008 SHALL have ports game_ack out 1, game_rdata out 2, game_err out 1: game-logic response.
REQ-009 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out 7, mem_wdata out 2, mem_rdata in 2: single-port board RAM with 1-cycle read latency.

Function
REQ-010 SHALL compute the address as y*BOARD_DIM + x, 7 bits, range 0..120 at default.
REQ-011 SHALL treat x>=BOARD_DIM or y>=BOARD_DIM as out-of-range: no mem_en; display gets disp_valid=1, disp_data=0; game gets game_ack=1, game_rdata=0, game_err=1 for one cycle.
REQ-012 SHALL use an FSM with states ARB and GAME_RESP.
REQ-013 In ARB, SHALL grant the display if disp_req=1 and no forced grant is due; otherwise SHALL grant the game if game_req=1; otherwise mem_en=0.
REQ-014 On a game grant, SHALL drive mem_en=1, mem_we=game_we, mem_addr, mem_wdata that cycle and SHALL move to GAME_RESP.
REQ-015 In GAME_RESP, SHALL assert game_ack=1 for exactly one cycle, with game_rdata=mem_rdata (reads) or 0 (writes), and SHALL return to ARB.
REQ-016 In GAME_RESP, SHALL NOT grant the game; a display request in that cycle SHALL still be issued.
REQ-017 SHALL give display reads a fixed latency of 1 cycle: disp_valid=1 and disp_data=mem_rdata in the cycle after the issue.
REQ-018 SHALL have starve_cnt count cycles with game_req=1 in ARB and no game grant. It SHALL clear on a game grant or when game_req=0, and SHALL saturate at STARVE_LIMIT.
REQ-019 When starve_cnt==STARVE_LIMIT and game_req=1, SHALL grant the game over the display. A concurrent disp_req SHALL get disp_stall=1 in the following cycle and disp_valid=0.
REQ-020 SHALL never assert disp_valid and disp_stall in the same cycle.
REQ-021 SHALL never assert mem_en for two requesters in one cycle; a write SHALL be visible to a read issued in the next cycle.

Reset
REQ-022 On rst=1, SHALL force state=ARB, starve_cnt=0, and all outputs to 0 at the next edge.
REQ-023 A game access in flight at reset SHALL be abandoned with no ack; the requester re-issues after reset.

Configuration
REQ-024 With BOARD_ARB_STARVE_GUARD_EN defined, REQ-018/REQ-019 SHALL be active.
REQ-025 Without BOARD_ARB_STARVE_GUARD_EN, SHALL give the display strict priority, SHALL tie disp_stall to 0, and SHALL omit starve_cnt.

Structure
REQ-026 SHALL place BOARD_DIM, the cell encodings (2'b00 empty, 01 attacker, 10 defender, 11 king) and the state enum in a shared package, board_pkg.
REQ-027 SHALL put the coordinate-to-address multiply and range check in one sub-module, board_addr_calc, used once for each requester.

Verification
REQ-028 rst held 3 cycles -> all outputs 0, state ARB.
REQ-029 disp_req with (3,4), RAM[47]=2'b10 -> mem_addr=47, next cycle disp_valid=1, disp_data=2'b10.
REQ-030 game write (0,0) data 2'b11 with display idle -> mem_we=1, addr 0, game_ack next cycle; then display read (0,0) -> 2'b11.
REQ-031 disp_req held high, game_req read (10,10), guard enabled, STARVE_LIMIT=8 -> game granted 9th cycle at addr 120, disp_stall=1 one cycle later, game_ack following.
REQ-032 game_req with x=11 -> no mem_en, game_ack=1, game_err=1, game_rdata=0 next cycle.
REQ-033 rst asserted in the GAME_RESP cycle -> no game_ack, outputs 0 next edge.

Source files
------------

// File: rtl/board_pkg.sv
// Shared board constants: default board size, cell encodings and arbiter state enum.
package board_pkg;

    localparam int unsigned BOARD_DIM = 11;

    typedef enum logic [1:0] {
        CELL_EMPTY    = 2'b00,
        CELL_ATTACKER = 2'b01,
        CELL_DEFENDER = 2'b10,
        CELL_KING     = 2'b11
    } cell_e;

    typedef enum logic {
        ARB       = 1'b0,
        GAME_RESP = 1'b1
    } arb_state_e;

endpackage

// File: rtl/board_addr_calc.sv
// Board coordinate to linear RAM address (y*BOARD_DIM + x) with range check.
module board_addr_calc #(
    parameter int unsigned BOARD_DIM = board_pkg::BOARD_DIM
) (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    output logic [6:0] addr_o,
    output logic       in_range_o
);

    localparam logic [6:0] DIM7 = 7'(BOARD_DIM);

    // Address is meaningless when out of range; callers gate on in_range_o.
    assign addr_o     = 7'(y_i) * DIM7 + 7'(x_i);
    assign in_range_o = (32'(x_i) < BOARD_DIM) && (32'(y_i) < BOARD_DIM);

endmodule

// File: rtl/board_mem_arbiter.sv
// Arbitrates display reads and game-logic accesses onto one single-port board RAM.
// Define BOARD_ARB_STARVE_GUARD_EN to force the game through after STARVE_LIMIT denials.
module board_mem_arbiter
    import board_pkg::*;
#(
    parameter int unsigned BOARD_DIM    = board_pkg::BOARD_DIM,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       disp_req,
    input  logic [3:0] disp_x,
    input  logic [3:0] disp_y,
    output logic       disp_valid,
    output logic [1:0] disp_data,
    output logic       disp_stall,
    input  logic       game_req,
    input  logic       game_we,
    input  logic [3:0] game_x,
    input  logic [3:0] game_y,
    input  logic [1:0] game_wdata,
    output logic       game_ack,
    output logic [1:0] game_rdata,
    output logic       game_err,
    output logic       mem_en,
    output logic       mem_we,
    output logic [6:0] mem_addr,
    output logic [1:0] mem_wdata,
    input  logic [1:0] mem_rdata
);

    logic [6:0] disp_addr, game_addr;
    logic       disp_in, game_in;

    board_addr_calc #(.BOARD_DIM(BOARD_DIM)) u_disp_addr (
        .x_i(disp_x), .y_i(disp_y), .addr_o(disp_addr), .in_range_o(disp_in)
    );

    board_addr_calc #(.BOARD_DIM(BOARD_DIM)) u_game_addr (
        .x_i(game_x), .y_i(game_y), .addr_o(game_addr), .in_range_o(game_in)
    );

    arb_state_e state_q, state_d;
    logic disp_vld_q, disp_vld_d, disp_oor_q, disp_oor_d;
    logic disp_stall_q, disp_stall_d;
    logic game_err_q, game_err_d, game_wr_q, game_wr_d;
    logic force_game, grant_disp, grant_game;

`ifdef BOARD_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign force_game = (state_q == ARB) && game_req && (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!game_req || grant_game) begin
            starve_cnt_d = '0;
        end else if ((state_q == ARB) && (starve_cnt_q != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) starve_cnt_q <= '0;
        else     starve_cnt_q <= starve_cnt_d;
    end
`else
    assign force_game = 1'b0;
`endif

    always_comb begin
        state_d      = ARB;
        grant_disp   = 1'b0;
        grant_game   = 1'b0;
        disp_vld_d   = 1'b0;
        disp_oor_d   = 1'b0;
        disp_stall_d = 1'b0;
        game_err_d   = 1'b0;
        game_wr_d    = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        game_ack     = 1'b0;
        game_err     = 1'b0;
        game_rdata   = '0;
        disp_valid   = disp_vld_q;
        disp_data    = (disp_vld_q && !disp_oor_q) ? mem_rdata : '0;
        disp_stall   = disp_stall_q;

        unique case (state_q)
            ARB: begin
                grant_disp = disp_req && !force_game;
                grant_game = game_req && !grant_disp;
            end
            GAME_RESP: begin
                grant_disp = disp_req;
                game_ack   = 1'b1;
                game_err   = game_err_q;
                game_rdata = (game_err_q || game_wr_q) ? '0 : mem_rdata;
            end
            default: ;
        endcase

        disp_stall_d = force_game && disp_req;

        if (grant_disp) begin
            disp_vld_d = 1'b1;
            disp_oor_d = !disp_in;
            mem_en     = disp_in;
            mem_addr   = disp_in ? disp_addr : '0;
        end

        if (grant_game) begin
            state_d    = GAME_RESP;
            game_err_d = !game_in;
            game_wr_d  = game_we;
            mem_en     = game_in;
            mem_we     = game_in && game_we;
            mem_addr   = game_in ? game_addr : '0;
            mem_wdata  = (game_in && game_we) ? game_wdata : '0;
        end

        // Outputs are combinational from state and requests, so reset masks them directly.
        if (rst) begin
            mem_en     = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
            game_ack   = 1'b0;
            game_err   = 1'b0;
            game_rdata = '0;
            disp_valid = 1'b0;
            disp_data  = '0;
            disp_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB;
            disp_vld_q   <= 1'b0;
            disp_oor_q   <= 1'b0;
            disp_stall_q <= 1'b0;
            game_err_q   <= 1'b0;
            game_wr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            disp_vld_q   <= disp_vld_d;
            disp_oor_q   <= disp_oor_d;
            disp_stall_q <= disp_stall_d;
            game_err_q   <= game_err_d;
            game_wr_q    <= game_wr_d;
        end
    end

endmodule
